reprog_selectmap_ctrl: RTL and testbench

REPROG_SELECTMAP_CTRL -- requirements
Module: reprog_selectmap_ctrl

---
 rtl/reprog_pkg.sv | 24 ++
 rtl/reprog_fifo.sv | 71 +++++++
 rtl/reprog_selectmap_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_reprog_selectmap_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reprog_pkg.sv
// Shared types and constants for the SelectMAP reprogramming controller.
// Holds the controller state enum, the REPROG_CTRL field layout and byte helpers.
package reprog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROG_LOW,
        ST_WAIT_INIT,
        ST_LOAD,
        ST_ERROR
    } state_t;

    localparam int unsigned CTRL_RESTART_BIT = 0;
    localparam int unsigned BYTES_PER_WORD   = 4;

    function automatic logic [7:0] bit_reverse8(input logic [7:0] b);
        logic [7:0] r;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/reprog_fifo.sv
// Synchronous show-ahead FIFO buffering bitstream words ahead of the SelectMAP port.
// flush empties the buffer and overrides any push/pop in the same cycle.
module reprog_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
            if (do_pop)  rd_ptr_d = AW'(rd_ptr_q + 1'b1);
            case ({do_push, do_pop})
                2'b10:   count_d = CW'(count_q + 1'b1);
                2'b01:   count_d = CW'(count_q - 1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; validity is tracked solely by count_q.
    always_ff @(posedge CLK) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/reprog_selectmap_ctrl.sv
// PCI-driven SelectMAP configuration controller: PROG_B pulse, INIT_B wait, byte-wise load.
// Define REPROG_BITSWAP_EN to bit-reverse every byte driven onto cnet_d.
module reprog_selectmap_ctrl
    import reprog_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned PROG_LOW_CYCLES = 64,
    parameter int unsigned INIT_TIMEOUT    = 4096
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ctrl_wr,
    input  logic [31:0] ctrl_data,
    input  logic        data_wr,
    input  logic [31:0] data_in,
    output logic        data_full,
    output logic        cnet_prog_b,
    input  logic        cnet_init_b,
    input  logic        cnet_done,
    output logic        cnet_cs_b,
    output logic        cnet_rdwr_b,
    output logic        cnet_cclk,
    output logic [7:0]  cnet_d,
    output logic        busy,
    output logic        error,
    output logic        done_seen
);

    localparam logic [31:0] PROG_LAST = 32'(PROG_LOW_CYCLES - 1);
    localparam logic [31:0] INIT_LAST = 32'(INIT_TIMEOUT - 1);
    localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        phase_q, phase_d;
    logic        finishing_q, finishing_d;
    logic        done_prev_q, done_prev_d;
    logic        done_seen_q, done_seen_d;

    logic        restart;
    logic        done_rise;
    logic        emit;
    logic        fifo_push, fifo_pop, fifo_flush;
    logic        fifo_empty, fifo_full;
    logic [31:0] fifo_head;
    logic [7:0]  raw_byte;
    logic        ctrl_unused;

    assign ctrl_unused = ^ctrl_data;
    assign restart     = ctrl_wr && ctrl_data[CTRL_RESTART_BIT];
    assign done_rise   = cnet_done && !done_prev_q;
    // A word in flight keeps its head entry until the last byte, so emptiness only matters between words.
    assign emit        = (state_q == ST_LOAD) && ((byte_idx_q != '0) || phase_q || !fifo_empty);
    assign fifo_push   = data_wr && !fifo_full && !restart && (state_q != ST_ERROR);

    reprog_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (data_in),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            byte_idx_q  <= '0;
            phase_q     <= 1'b0;
            finishing_q <= 1'b0;
            done_prev_q <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_idx_q  <= byte_idx_d;
            phase_q     <= phase_d;
            finishing_q <= finishing_d;
            done_prev_q <= done_prev_d;
            done_seen_q <= done_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_idx_d  = byte_idx_q;
        phase_d     = phase_q;
        finishing_d = finishing_q;
        done_prev_d = cnet_done;
        done_seen_d = done_seen_q;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;

        if (restart) begin
            state_d     = ST_PROG_LOW;
            cnt_d       = '0;
            byte_idx_d  = '0;
            phase_d     = 1'b0;
            finishing_d = 1'b0;
            done_seen_d = 1'b0;
            fifo_flush  = 1'b1;
        end else begin
            case (state_q)
                ST_PROG_LOW: begin
                    if (cnt_q == PROG_LAST) begin
                        state_d = ST_WAIT_INIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                ST_WAIT_INIT: begin
                    if (cnet_init_b) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                    end else if (cnt_q == INIT_LAST) begin
                        state_d = ST_ERROR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                ST_LOAD: begin
                    if (!cnet_init_b) begin
                        state_d     = ST_ERROR;
                        byte_idx_d  = '0;
                        phase_d     = 1'b0;
                        finishing_d = 1'b0;
                    end else begin
                        if (done_rise) begin
                            done_seen_d = 1'b1;
                            finishing_d = 1'b1;
                        end
                        // After DONE, the word in flight completes as startup clocks, then the rest is dropped.
                        if (emit) begin
                            if (!phase_q) begin
                                phase_d = 1'b1;
                            end else begin
                                phase_d    = 1'b0;
                                byte_idx_d = 2'(byte_idx_q + 2'd1);
                                if (byte_idx_q == LAST_BYTE) begin
                                    fifo_pop = 1'b1;
                                    if (finishing_q || done_rise) begin
                                        state_d     = ST_IDLE;
                                        finishing_d = 1'b0;
                                        fifo_flush  = 1'b1;
                                    end
                                end
                            end
                        end else if (finishing_q || done_rise) begin
                            state_d     = ST_IDLE;
                            finishing_d = 1'b0;
                            fifo_flush  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (byte_idx_q)
            2'd0:    raw_byte = fifo_head[31:24];
            2'd1:    raw_byte = fifo_head[23:16];
            2'd2:    raw_byte = fifo_head[15:8];
            default: raw_byte = fifo_head[7:0];
        endcase

        cnet_prog_b = (state_q != ST_PROG_LOW);
        cnet_rdwr_b = 1'b0;
        cnet_cs_b   = !emit;
        cnet_cclk   = emit && phase_q;
        cnet_d      = '0;
        if (emit) begin
`ifdef REPROG_BITSWAP_EN
            cnet_d = bit_reverse8(raw_byte);
`else
            cnet_d = raw_byte;
`endif
        end

        busy      = (state_q == ST_PROG_LOW) || (state_q == ST_WAIT_INIT) || (state_q == ST_LOAD);
        error     = (state_q == ST_ERROR);
        done_seen = done_seen_q;
        data_full = fifo_full;
    end

endmodule

// File: tb/tb_reprog_selectmap_ctrl.sv
// Directed self-checking bench for reprog_selectmap_ctrl with default parameters.
// Captures cnet_d on every cnet_cclk rising edge and counts PROG_B-low cycles.
module tb_reprog_selectmap_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        ctrl_wr;
    logic [31:0] ctrl_data;
    logic        data_wr;
    logic [31:0] data_in;
    logic        data_full;
    logic        cnet_prog_b;
    logic        cnet_init_b;
    logic        cnet_done;
    logic        cnet_cs_b;
    logic        cnet_rdwr_b;
    logic        cnet_cclk;
    logic [7:0]  cnet_d;
    logic        busy;
    logic        error;
    logic        done_seen;

    int          checks;
    int          failures;
    int          plow;
    logic [7:0]  bytes_q[$];

    reprog_selectmap_ctrl #(
        .FIFO_DEPTH      (4),
        .PROG_LOW_CYCLES (64),
        .INIT_TIMEOUT    (4096)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .ctrl_wr     (ctrl_wr),
        .ctrl_data   (ctrl_data),
        .data_wr     (data_wr),
        .data_in     (data_in),
        .data_full   (data_full),
        .cnet_prog_b (cnet_prog_b),
        .cnet_init_b (cnet_init_b),
        .cnet_done   (cnet_done),
        .cnet_cs_b   (cnet_cs_b),
        .cnet_rdwr_b (cnet_rdwr_b),
        .cnet_cclk   (cnet_cclk),
        .cnet_d      (cnet_d),
        .busy        (busy),
        .error       (error),
        .done_seen   (done_seen)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge cnet_cclk) bytes_q.push_back(cnet_d);

    always @(negedge CLK) if (RST_N && !cnet_prog_b) plow++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_restart();
        ctrl_wr   = 1'b1;
        ctrl_data = 32'h1;
        tick(1);
        ctrl_wr   = 1'b0;
        ctrl_data = 32'h0;
    endtask

    task automatic write_word(input logic [31:0] w);
        data_wr = 1'b1;
        data_in = w;
        tick(1);
        data_wr = 1'b0;
    endtask

    task automatic write_retry(input logic [31:0] w);
        int i;
        i = 0;
        while (data_full && i < 200) begin
            tick(1);
            i++;
        end
        write_word(w);
    endtask

    task automatic wait_prog_release();
        int i;
        i = 0;
        while (!cnet_prog_b && i < 200) begin
            tick(1);
            i++;
        end
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int i;
        i = 0;
        while (bytes_q.size() < n && i < budget) begin
            tick(1);
            i++;
        end
    endtask

    initial begin
        int n;
        logic [31:0] words5 [5];
        logic [31:0] words_d [5];

        checks = 0; failures = 0; plow = 0;
        RST_N = 1'b0; ctrl_wr = 1'b0; ctrl_data = '0; data_wr = 1'b0; data_in = '0;
        cnet_init_b = 1'b0; cnet_done = 1'b0;
        tick(3);

        // Reset state
        check_eq("rst_prog_b", 32'(cnet_prog_b), 32'd1);
        check_eq("rst_cs_b", 32'(cnet_cs_b), 32'd1);
        check_eq("rst_rdwr_b", 32'(cnet_rdwr_b), 32'd0);
        check_eq("rst_cclk", 32'(cnet_cclk), 32'd0);
        check_eq("rst_d", 32'(cnet_d), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_done_seen", 32'(done_seen), 32'd0);
        check_eq("rst_full", 32'(data_full), 32'd0);
        RST_N = 1'b1;
        tick(2);

        // Basic load: PROG_B width, INIT_B after 10 cycles, one word
        plow = 0; bytes_q.delete();
        do_restart();
        check_eq("busy_prog_low", 32'(busy), 32'd1);
        write_word(32'hA1B2C3D4);
        wait_prog_release();
        tick(10);
        cnet_init_b = 1'b1;
        wait_bytes(4, 100);
        tick(10);
        check_eq("prog_low_width", 32'(plow), 32'd64);
        check_eq("basic_nbytes", 32'(bytes_q.size()), 32'd4);
        if (bytes_q.size() == 4) begin
            check_eq("basic_b0", 32'(bytes_q[0]), 32'hA1);
            check_eq("basic_b1", 32'(bytes_q[1]), 32'hB2);
            check_eq("basic_b2", 32'(bytes_q[2]), 32'hC3);
            check_eq("basic_b3", 32'(bytes_q[3]), 32'hD4);
        end
        check_eq("load_empty_cs_b", 32'(cnet_cs_b), 32'd1);
        check_eq("load_empty_cclk", 32'(cnet_cclk), 32'd0);
        check_eq("load_busy", 32'(busy), 32'd1);

        // INIT_B timeout
        cnet_init_b = 1'b0; plow = 0; bytes_q.delete();
        do_restart();
        wait_prog_release();
        n = 0;
        while (!error && n < 5000) begin
            tick(1);
            n++;
        end
        check_eq("timeout_cycles", 32'(n), 32'd4096);
        check_eq("timeout_error", 32'(error), 32'd1);
        check_eq("timeout_busy", 32'(busy), 32'd0);
        check_eq("timeout_cs_b", 32'(cnet_cs_b), 32'd1);
        check_eq("timeout_no_cclk", 32'(bytes_q.size()), 32'd0);

        // FIFO full and drop
        bytes_q.delete();
        do_restart();
        check_eq("restart_clears_error", 32'(error), 32'd0);
        write_word(32'h01020304);
        write_word(32'h05060708);
        write_word(32'h090A0B0C);
        check_eq("full_after_3", 32'(data_full), 32'd0);
        write_word(32'h0D0E0F10);
        check_eq("full_after_4", 32'(data_full), 32'd1);
        write_word(32'hDEADBEEF);
        wait_prog_release();
        cnet_init_b = 1'b1;
        wait_bytes(16, 300);
        tick(40);
        check_eq("full_nbytes", 32'(bytes_q.size()), 32'd16);
        if (bytes_q.size() == 16) begin
            check_eq("full_b4", 32'(bytes_q[4]), 32'h05);
            check_eq("full_b15", 32'(bytes_q[15]), 32'h10);
        end
        check_eq("full_drained", 32'(data_full), 32'd0);

        // INIT_B drop mid-word
        bytes_q.delete();
        do_restart();
        write_word(32'h11223344);
        wait_bytes(2, 200);
        cnet_init_b = 1'b0;
        tick(1);
        check_eq("crc_error", 32'(error), 32'd1);
        check_eq("crc_busy", 32'(busy), 32'd0);
        check_eq("crc_cclk", 32'(cnet_cclk), 32'd0);
        tick(5);
        check_eq("crc_nbytes", 32'(bytes_q.size()), 32'd2);
        do_restart();
        check_eq("crc_restart_error", 32'(error), 32'd0);
        check_eq("crc_restart_prog_b", 32'(cnet_prog_b), 32'd0);

        // DONE during word 3 of 5
        words_d[0] = 32'h10111213; words_d[1] = 32'h20212223; words_d[2] = 32'h30313233;
        words_d[3] = 32'h40414243; words_d[4] = 32'h50515253;
        cnet_init_b = 1'b1; bytes_q.delete();
        do_restart();
        for (int i = 0; i < 5; i++) write_retry(words_d[i]);
        wait_bytes(9, 400);
        cnet_done = 1'b1;
        tick(60);
        check_eq("done_seen", 32'(done_seen), 32'd1);
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_error", 32'(error), 32'd0);
        check_eq("done_nbytes", 32'(bytes_q.size()), 32'd12);
        if (bytes_q.size() == 12) begin
            check_eq("done_b8", 32'(bytes_q[8]), 32'h30);
            check_eq("done_b11", 32'(bytes_q[11]), 32'h33);
        end
        cnet_done = 1'b0;
        write_word(32'h0); write_word(32'h0); write_word(32'h0);
        check_eq("done_flush_3", 32'(data_full), 32'd0);
        write_word(32'h0);
        check_eq("done_flush_4", 32'(data_full), 32'd1);

        // Restart with simultaneous data write: word discarded, FIFO flushed
        bytes_q.delete();
        ctrl_wr = 1'b1; ctrl_data = 32'h1; data_wr = 1'b1; data_in = 32'hCAFEF00D;
        tick(1);
        ctrl_wr = 1'b0; ctrl_data = '0; data_wr = 1'b0;
        check_eq("restart_done_seen_clr", 32'(done_seen), 32'd0);
        tick(150);
        check_eq("restart_wins_nbytes", 32'(bytes_q.size()), 32'd0);
        check_eq("restart_wins_cs_b", 32'(cnet_cs_b), 32'd1);
        check_eq("restart_wins_busy", 32'(busy), 32'd1);

        // Byte order / bit reversal; resumes from an empty LOAD
        write_word(32'h01800000);
        wait_bytes(4, 60);
        check_eq("swap_nbytes", 32'(bytes_q.size()), 32'd4);
        if (bytes_q.size() == 4) begin
`ifdef REPROG_BITSWAP_EN
            check_eq("swap_b0", 32'(bytes_q[0]), 32'h80);
            check_eq("swap_b1", 32'(bytes_q[1]), 32'h01);
`else
            check_eq("swap_b0", 32'(bytes_q[0]), 32'h01);
            check_eq("swap_b1", 32'(bytes_q[1]), 32'h80);
`endif
            check_eq("swap_b2", 32'(bytes_q[2]), 32'h00);
            check_eq("swap_b3", 32'(bytes_q[3]), 32'h00);
        end

        // Reset mid-LOAD
        bytes_q.delete();
        write_word(32'hAABBCCDD);
        wait_bytes(2, 60);
        RST_N = 1'b0;
        #1;
        check_eq("midrst_cclk", 32'(cnet_cclk), 32'd0);
        check_eq("midrst_cs_b", 32'(cnet_cs_b), 32'd1);
        check_eq("midrst_prog_b", 32'(cnet_prog_b), 32'd1);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_d", 32'(cnet_d), 32'd0);
        tick(5);
        RST_N = 1'b1;
        tick(20);
        check_eq("midrst_nbytes", 32'(bytes_q.size()), 32'd2);
        check_eq("midrst_idle_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
